// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the RV32 core: stage indices, scoreboard entry, select-width helper.
package rv_pipe_pkg;

  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  localparam int unsigned SB_RA_W = 5;

  typedef struct packed {
    logic               valid;
    logic [SB_RA_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

  // 0 selects the register file, k+1 selects stage k
  function automatic int unsigned fwd_sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_fwd_mux.sv
// Priority match of one source operand against the in-flight scoreboard; youngest producer wins.
module rv_fwd_mux
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned SEL_W     = fwd_sel_w(FWD_DEPTH)
) (
  input  logic [RA_W-1:0]           rs,
  input  logic                      use_rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [FWD_DEPTH*XLEN-1:0] stage_result,
  input  sb_entry_t [FWD_DEPTH-1:0] sb,
  output logic [XLEN-1:0]           op_c,
  output logic [SEL_W-1:0]          sel_c,
  output logic                      load_stall_c
);

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    op_c         = rf_data;
    sel_c        = '0;
    load_stall_c = 1'b0;
    for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
      if (sb[FWD_DEPTH-1-i].valid && sb[FWD_DEPTH-1-i].regwrite && use_rs &&
          (rs != '0) && (sb[FWD_DEPTH-1-i].rd == SB_RA_W'(rs))) begin
        op_c         = stage_result[(FWD_DEPTH-1-i)*XLEN +: XLEN];
        sel_c        = SEL_W'(FWD_DEPTH - i);
        load_stall_c = sb[FWD_DEPTH-1-i].is_load && ((FWD_DEPTH-1-i) < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/rv_hazard_fwd_unit.sv
// Hazard/forwarding controller beside ID: shadow scoreboard, operand forwarding,
// load-use stall, redirect kill and saturating stall/flush counters.
module rv_hazard_fwd_unit
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RA_W           = 5,
  parameter int unsigned FWD_DEPTH      = 3,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned REDIRECT_STAGE = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid_i,
  input  logic [RA_W-1:0]                 id_rs1_i,
  input  logic [RA_W-1:0]                 id_rs2_i,
  input  logic                            id_use_rs1_i,
  input  logic                            id_use_rs2_i,
  input  logic [RA_W-1:0]                 id_rd_i,
  input  logic                            id_regwrite_i,
  input  logic                            id_is_load_i,
  input  logic [XLEN-1:0]                 rf_rs1_data_i,
  input  logic [XLEN-1:0]                 rf_rs2_data_i,
  input  logic [FWD_DEPTH*XLEN-1:0]       stage_result_i,
  input  logic                            redirect_i,
  output logic [XLEN-1:0]                 opa_o,
  output logic [XLEN-1:0]                 opb_o,
  output logic [fwd_sel_w(FWD_DEPTH)-1:0] fwd_sel_a_o,
  output logic [fwd_sel_w(FWD_DEPTH)-1:0] fwd_sel_b_o,
  output logic                            stall_o,
  output logic [REDIRECT_STAGE:0]         kill_o,
  output logic [CNT_W-1:0]                stall_cnt_o,
  output logic [CNT_W-1:0]                flush_cnt_o
);

  localparam int unsigned      SEL_W   = fwd_sel_w(FWD_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t [FWD_DEPTH-1:0] sb_q;
  sb_entry_t                 id_entry_c;
  logic                      stall_a_c;
  logic                      stall_b_c;

  rv_fwd_mux #(
    .XLEN(XLEN), .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_fwd_a (
    .rs(id_rs1_i), .use_rs(id_use_rs1_i), .rf_data(rf_rs1_data_i),
    .stage_result(stage_result_i), .sb(sb_q),
    .op_c(opa_o), .sel_c(fwd_sel_a_o), .load_stall_c(stall_a_c)
  );

  rv_fwd_mux #(
    .XLEN(XLEN), .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_fwd_b (
    .rs(id_rs2_i), .use_rs(id_use_rs2_i), .rf_data(rf_rs2_data_i),
    .stage_result(stage_result_i), .sb(sb_q),
    .op_c(opb_o), .sel_c(fwd_sel_b_o), .load_stall_c(stall_b_c)
  );

  // A redirect overrides any load-use stall in the same cycle
  assign stall_o = (stall_a_c | stall_b_c) & ~redirect_i;
  assign kill_o  = {(REDIRECT_STAGE+1){redirect_i}};

  always_comb begin
    id_entry_c = '0;
    if (id_valid_i && !stall_o && !kill_o[0]) begin
      id_entry_c.valid    = 1'b1;
      id_entry_c.rd       = SB_RA_W'(id_rd_i);
      id_entry_c.regwrite = id_regwrite_i;
      id_entry_c.is_load  = id_is_load_i;
    end
  end

  // Wrong-path entries younger than the redirecting stage are dropped as they shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q[0] <= id_entry_c;
      for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
        sb_q[k] <= (redirect_i && ((k - 1) < REDIRECT_STAGE)) ? sb_entry_t'('0) : sb_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect_i && (flush_cnt_o != CNT_MAX)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_hazard_fwd_unit.sv
// Self-checking bench for rv_hazard_fwd_unit: directed hazard scenarios plus random traffic
// compared against an in-bench pipeline model.
module tb_rv_hazard_fwd_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned D    = 3;
  localparam int unsigned LL   = 1;
  localparam int unsigned RS   = 1;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            id_valid = 1'b0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0, id_is_load = 1'b0;
  logic [31:0]     rf1 = '0, rf2 = '0;
  logic [31:0]     sres [D];
  logic [D*32-1:0] stage_result;
  logic            redirect = 1'b0;
  logic [31:0]     opa, opb;
  logic [1:0]      sel_a, sel_b;
  logic            stall;
  logic [RS:0]     kill;
  logic [CW-1:0]   stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference pipeline: one record per tracked stage, index = stages after ID
  logic       m_valid [D];
  logic [4:0] m_rd    [D];
  logic       m_rw    [D];
  logic       m_ld    [D];
  int         m_scnt, m_fcnt;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < D; k++) stage_result[k*32 +: 32] = sres[k];
  end

  rv_hazard_fwd_unit #(
    .XLEN(XLEN), .RA_W(5), .FWD_DEPTH(D), .LOAD_LAT(LL), .REDIRECT_STAGE(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load),
    .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .stage_result_i(stage_result),
    .redirect_i(redirect),
    .opa_o(opa), .opb_o(opb), .fwd_sel_a_o(sel_a), .fwd_sel_b_o(sel_b),
    .stall_o(stall), .kill_o(kill), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      m_valid[k] = 1'b0; m_rd[k] = '0; m_rw[k] = 1'b0; m_ld[k] = 1'b0;
    end
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  // Youngest in-flight writer of a nonzero register supplies the operand
  task automatic model_operand(input logic [4:0] rs, input logic use_rs, input logic [31:0] rf,
                               output logic [31:0] op, output int sel, output logic ld_stall);
    logic found;
    found = 1'b0; op = rf; sel = 0; ld_stall = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (!found && m_valid[k] && m_rw[k] && use_rs && rs != 0 && m_rd[k] == rs) begin
        found = 1'b1; op = sres[k]; sel = k + 1; ld_stall = m_ld[k] && (k < LL);
      end
    end
  endtask

  // Compare all outputs against the model, then advance model and DUT one clock
  task automatic tick();
    logic [31:0] ea, eb;
    int          sa, sb;
    logic        la, lb, est;
    #1;
    model_operand(id_rs1, id_use_rs1, rf1, ea, sa, la);
    model_operand(id_rs2, id_use_rs2, rf2, eb, sb, lb);
    est = (la || lb) && !redirect;
    check("opa", 64'(opa), 64'(ea));
    check("opb", 64'(opb), 64'(eb));
    check("fwd_sel_a", 64'(sel_a), 64'(sa));
    check("fwd_sel_b", 64'(sel_b), 64'(sb));
    check("stall", 64'(stall), 64'(est));
    check("kill", 64'(kill), redirect ? 64'h3 : 64'h0);
    check("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    check("flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
    @(posedge clk);
    for (int k = D - 1; k >= 1; k--) begin
      if (redirect && (k - 1) < RS) begin
        m_valid[k] = 1'b0;
      end else begin
        m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1];
      end
    end
    m_valid[0] = id_valid && !est && !redirect;
    m_rd[0] = id_rd; m_rw[0] = id_regwrite; m_ld[0] = id_is_load;
    if (est && m_scnt < CMAX) m_scnt++;
    if (redirect && m_fcnt < CMAX) m_fcnt++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without an edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_sel_a", 64'(sel_a), 64'h0);
    check("rst_opa", 64'(opa), 64'(rf1));
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
  endtask

  initial begin
    for (int k = 0; k < D; k++) sres[k] = 32'h100 + 32'(k);
    rf1 = 32'h1234_0001;
    rf2 = 32'h1234_0002;
    model_clear();
    @(negedge clk);
    do_reset();

    // Back-to-back ALU dependency
    set_id(1, 0, 0, 0, 0, 5, 1, 0); tick();
    set_id(1, 5, 1, 0, 0, 8, 1, 0); sres[0] = 32'h11;
    #1;
    check("s1_sel_a", 64'(sel_a), 64'h1);
    check("s1_opa", 64'(opa), 64'h11);
    check("s1_stall", 64'(stall), 64'h0);
    tick();

    // Load-use: one stall cycle, then MEM forwarding
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 1); tick();
    set_id(1, 6, 1, 0, 0, 9, 1, 0);
    #1;
    check("s2_stall", 64'(stall), 64'h1);
    tick();
    sres[1] = 32'hDEAD;
    #1;
    check("s2_stall_after", 64'(stall), 64'h0);
    check("s2_sel_a", 64'(sel_a), 64'h2);
    check("s2_opa", 64'(opa), 64'hDEAD);
    check("s2_stall_cnt", 64'(stall_cnt), 64'h1);
    tick();

    // Two in-flight producers of x7
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1, 0); tick();
    set_id(1, 0, 0, 0, 0, 7, 1, 0); tick();
    set_id(1, 7, 1, 7, 1, 3, 1, 0); sres[0] = 32'hA; sres[1] = 32'hB;
    #1;
    check("s3_opa", 64'(opa), 64'hA);
    check("s3_sel_b", 64'(sel_b), 64'h1);
    tick();

    // x0 destination is never forwarded
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 1, 0); tick();
    set_id(1, 0, 1, 0, 0, 4, 1, 0); rf1 = 32'h0; sres[0] = 32'h55;
    #1;
    check("s4_sel_a", 64'(sel_a), 64'h0);
    check("s4_opa", 64'(opa), 64'h0);
    tick();

    // Redirect coinciding with a load-use stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 1); tick();
    set_id(1, 6, 1, 0, 0, 9, 1, 0); redirect = 1'b1;
    #1;
    check("s5_kill", 64'(kill), 64'h3);
    check("s5_stall", 64'(stall), 64'h0);
    tick();
    redirect = 1'b0;
    set_id(0, 9, 1, 0, 0, 0, 0, 0); sres[0] = 32'h77;
    #1;
    check("s5_no_fwd_entry0", 64'(sel_a), 64'h0);
    check("s5_flush_cnt", 64'(flush_cnt), 64'h1);
    check("s5_stall_cnt", 64'(stall_cnt), 64'h0);
    tick();

    // Reset asserted during a stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1, 1); tick();
    set_id(1, 6, 1, 0, 0, 9, 1, 0);
    #1;
    check("s6_stall_pre", 64'(stall), 64'h1);
    tick();
    tick();
    do_reset();
    #1;
    check("s6_sel_a_post", 64'(sel_a), 64'h0);
    tick();

    // Random traffic on a small register window to provoke frequent hazards
    for (int n = 0; n < 3000; n++) begin
      set_id(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
      rf1 = $urandom; rf2 = $urandom;
      for (int k = 0; k < D; k++) sres[k] = $urandom;
      redirect = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      tick();
    end
    redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
